// File: rtl/hpdcache_victim_alloc_pkg.sv
// Shared helpers for the refill-side victim allocator.
package hpdcache_victim_alloc_pkg;

    // Widest way vector the one-hot checker handles.
    localparam int unsigned HPDCACHE_MAX_WAYS = 32;

    // True when exactly one bit of v is set.
    function automatic logic hpdcache_is_onehot(input logic [HPDCACHE_MAX_WAYS-1:0] v);
        return (v != '0) && ((v & (v - HPDCACHE_MAX_WAYS'(1))) == '0);
    endfunction

endpackage

// File: rtl/hpdcache_mux_1hot.sv
// One-hot selected AND-OR multiplexer over N packed WIDTH-bit lanes.
module hpdcache_mux_1hot #(
    parameter int unsigned N     = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic [N-1:0]       sel_i,
    input  logic [N*WIDTH-1:0] data_i,
    output logic [WIDTH-1:0]   data_o
);

    // OR together every lane whose select bit is set; zero when nothing is selected.
    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            data_o = data_o | (data_i[i*WIDTH +: WIDTH] & {WIDTH{sel_i[i]}});
        end
    end

endmodule

// File: rtl/hpdcache_victim_alloc.sv
// Refill-side victim allocator: reads the set directory, queries the PLRU for a
// victim, issues a write-back for dirty victims and returns the allocated way.
module hpdcache_victim_alloc
    import hpdcache_victim_alloc_pkg::*;
#(
    parameter int unsigned SETS      = 8,
    parameter int unsigned WAYS      = 4,
    parameter int unsigned TAG_WIDTH = 8,
    localparam int unsigned SetW     = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      alloc_req_valid_i,
    output logic                      alloc_req_ready_o,
    input  logic [SetW-1:0]           alloc_req_set_i,

    output logic                      dir_rd_o,
    output logic [SetW-1:0]           dir_rd_set_o,
    input  logic [WAYS-1:0]           dir_valid_i,
    input  logic [WAYS-1:0]           dir_dirty_i,
    input  logic [WAYS*TAG_WIDTH-1:0] dir_tags_i,

    output logic                      repl_o,
    output logic [SetW-1:0]           repl_set_o,
    output logic [WAYS-1:0]           repl_dir_valid_o,
    output logic                      repl_updt_plru_o,
    input  logic [WAYS-1:0]           victim_way_i,

    output logic                      wb_valid_o,
    input  logic                      wb_ready_i,
    output logic [SetW-1:0]           wb_set_o,
    output logic [WAYS-1:0]           wb_way_o,
    output logic [TAG_WIDTH-1:0]      wb_tag_o,

    output logic                      alloc_rsp_valid_o,
    input  logic                      alloc_rsp_ready_i,
    output logic [WAYS-1:0]           alloc_rsp_way_o,
    output logic                      alloc_rsp_evict_o
);

    typedef logic [SetW-1:0]      set_t;
    typedef logic [WAYS-1:0]      way_vector_t;
    typedef logic [TAG_WIDTH-1:0] tag_t;

    typedef enum logic [1:0] {
        StIdle,
        StSelect,
        StWb,
        StRsp
    } state_e;

    state_e      state_q;
    set_t        set_q;
    way_vector_t way_q;
    tag_t        tag_q;
    logic        evict_q;
    logic        dirty_q;
    logic        ready_q;
    logic        repl_q;
    logic        wb_valid_q;
    logic        rsp_valid_q;

    way_vector_t victim_hit;
    logic        evict_d;
    logic        dirty_d;
    tag_t        victim_tag;

    // Dirty only counts on a valid victim line.
    always_comb begin
        victim_hit = victim_way_i & dir_valid_i;
        evict_d    = |victim_hit;
        dirty_d    = |(victim_hit & dir_dirty_i);
    end

    hpdcache_mux_1hot #(
        .N     (WAYS),
        .WIDTH (TAG_WIDTH)
    ) i_tag_mux (
        .sel_i  (victim_way_i),
        .data_i (dir_tags_i),
        .data_o (victim_tag)
    );

    // Allocation FSM with registered handshake outputs and payload capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            set_q       <= '0;
            way_q       <= '0;
            tag_q       <= '0;
            evict_q     <= 1'b0;
            dirty_q     <= 1'b0;
            ready_q     <= 1'b1;
            repl_q      <= 1'b0;
            wb_valid_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (alloc_req_valid_i) begin
                        set_q   <= alloc_req_set_i;
                        ready_q <= 1'b0;
                        repl_q  <= 1'b1;
                        state_q <= StSelect;
                    end
                end
                StSelect: begin
                    way_q   <= victim_way_i;
                    evict_q <= evict_d;
                    dirty_q <= dirty_d;
                    tag_q   <= victim_tag;
                    repl_q  <= 1'b0;
                    if (dirty_d) begin
                        wb_valid_q <= 1'b1;
                        state_q    <= StWb;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= StRsp;
                    end
                end
                StWb: begin
                    if (wb_ready_i) begin
                        wb_valid_q  <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StRsp;
                    end
                end
                StRsp: begin
                    if (alloc_rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Directory read is issued in the accept cycle, from the incoming set.
    assign alloc_req_ready_o = ready_q;
    assign dir_rd_o          = ready_q & alloc_req_valid_i;
    assign dir_rd_set_o      = alloc_req_set_i;

    assign repl_o            = repl_q;
    assign repl_updt_plru_o  = repl_q;
    assign repl_set_o        = set_q;
    assign repl_dir_valid_o  = repl_q ? dir_valid_i : '0;

    assign wb_valid_o        = wb_valid_q;
    assign wb_set_o          = set_q;
    assign wb_way_o          = way_q;
    assign wb_tag_o          = tag_q;

    assign alloc_rsp_valid_o = rsp_valid_q;
    assign alloc_rsp_way_o   = way_q;
    assign alloc_rsp_evict_o = evict_q;

    // The PLRU must hand back exactly one victim way.
    a_victim_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
        repl_o |-> hpdcache_is_onehot(HPDCACHE_MAX_WAYS'(victim_way_i)));

    a_valids_exclusive : assert property (@(posedge clk_i) disable iff (rst_i)
        !(wb_valid_o && alloc_rsp_valid_o));

    // A write-back is only ever pending for a captured dirty victim.
    a_wb_dirty : assert property (@(posedge clk_i) disable iff (rst_i)
        wb_valid_o |-> dirty_q);

endmodule

// File: tb/tb_hpdcache_victim_alloc.sv
// Self-checking bench for hpdcache_victim_alloc with response/write-back scoreboards.
module tb_hpdcache_victim_alloc;

    localparam int unsigned SETS = 8;
    localparam int unsigned WAYS = 4;
    localparam int unsigned TW   = 8;
    localparam int unsigned SW   = 3;

    typedef struct {
        logic [WAYS-1:0] way;
        logic            evict;
    } rsp_t;

    typedef struct {
        logic [SW-1:0]   set;
        logic [WAYS-1:0] way;
        logic [TW-1:0]   tag;
    } wb_t;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b0;
    logic                 alloc_req_valid_i = 1'b0;
    logic                 alloc_req_ready_o;
    logic [SW-1:0]        alloc_req_set_i = '0;
    logic                 dir_rd_o;
    logic [SW-1:0]        dir_rd_set_o;
    logic [WAYS-1:0]      dir_valid_i = '0;
    logic [WAYS-1:0]      dir_dirty_i = '0;
    logic [WAYS*TW-1:0]   dir_tags_i = '0;
    logic                 repl_o;
    logic [SW-1:0]        repl_set_o;
    logic [WAYS-1:0]      repl_dir_valid_o;
    logic                 repl_updt_plru_o;
    logic [WAYS-1:0]      victim_way_i = 4'b0001;
    logic                 wb_valid_o;
    logic                 wb_ready_i = 1'b0;
    logic [SW-1:0]        wb_set_o;
    logic [WAYS-1:0]      wb_way_o;
    logic [TW-1:0]        wb_tag_o;
    logic                 alloc_rsp_valid_o;
    logic                 alloc_rsp_ready_i = 1'b0;
    logic [WAYS-1:0]      alloc_rsp_way_o;
    logic                 alloc_rsp_evict_o;

    int n_cmp  = 0;
    int n_fail = 0;

    rsp_t rsp_q[$];
    wb_t  wb_q[$];

    always #5 clk_i = ~clk_i;

    hpdcache_victim_alloc #(
        .SETS      (SETS),
        .WAYS      (WAYS),
        .TAG_WIDTH (TW)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .alloc_req_valid_i (alloc_req_valid_i),
        .alloc_req_ready_o (alloc_req_ready_o),
        .alloc_req_set_i   (alloc_req_set_i),
        .dir_rd_o          (dir_rd_o),
        .dir_rd_set_o      (dir_rd_set_o),
        .dir_valid_i       (dir_valid_i),
        .dir_dirty_i       (dir_dirty_i),
        .dir_tags_i        (dir_tags_i),
        .repl_o            (repl_o),
        .repl_set_o        (repl_set_o),
        .repl_dir_valid_o  (repl_dir_valid_o),
        .repl_updt_plru_o  (repl_updt_plru_o),
        .victim_way_i      (victim_way_i),
        .wb_valid_o        (wb_valid_o),
        .wb_ready_i        (wb_ready_i),
        .wb_set_o          (wb_set_o),
        .wb_way_o          (wb_way_o),
        .wb_tag_o          (wb_tag_o),
        .alloc_rsp_valid_o (alloc_rsp_valid_o),
        .alloc_rsp_ready_i (alloc_rsp_ready_i),
        .alloc_rsp_way_o   (alloc_rsp_way_o),
        .alloc_rsp_evict_o (alloc_rsp_evict_o)
    );

    task automatic next_cycle();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #12;
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        n_cmp++;
        if (alloc_req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", alloc_req_ready_o);
        end
        n_cmp++;
        if ({dir_rd_o, repl_o, repl_updt_plru_o, wb_valid_o, alloc_rsp_valid_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 00000",
                     {dir_rd_o, repl_o, repl_updt_plru_o, wb_valid_o, alloc_rsp_valid_o});
        end
        n_cmp++;
        if ({wb_set_o, wb_way_o, wb_tag_o, alloc_rsp_way_o, alloc_rsp_evict_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: got set %h way %b tag %h rway %b ev %b want all 0",
                     wb_set_o, wb_way_o, wb_tag_o, alloc_rsp_way_o, alloc_rsp_evict_o);
        end
    endtask

    // One full allocation from IDLE; starts and ends at a negedge in IDLE.
    task automatic run_alloc(input string name, input logic [SW-1:0] set,
                             input logic [WAYS-1:0] vld, input logic [WAYS-1:0] dty,
                             input logic [WAYS-1:0] vic, input logic [WAYS*TW-1:0] tags,
                             input int wb_hold, input int rsp_hold);
        logic          exp_evict;
        logic          exp_dirty;
        logic [TW-1:0] exp_tag;
        rsp_t          r;
        wb_t           w;
        int            waited;

        exp_evict = |(vic & vld);
        exp_dirty = |(vic & vld & dty);
        exp_tag   = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (vic[i]) exp_tag = tags[i*TW +: TW];
        end

        // Cycle 0: request accepted, directory read issued.
        alloc_req_valid_i = 1'b1;
        alloc_req_set_i   = set;
        #1;
        n_cmp++;
        if ({alloc_req_ready_o, dir_rd_o, dir_rd_set_o} !== {1'b1, 1'b1, set}) begin
            n_fail++;
            $display("FAIL %s_accept: got rdy %b rd %b set %h want 1 1 %h",
                     name, alloc_req_ready_o, dir_rd_o, dir_rd_set_o, set);
        end
        rsp_q.push_back('{way: vic, evict: exp_evict});
        if (exp_dirty) wb_q.push_back('{set: set, way: vic, tag: exp_tag});
        next_cycle();

        // Cycle 1: SELECT, directory data and PLRU victim presented.
        alloc_req_valid_i = 1'b0;
        dir_valid_i       = vld;
        dir_dirty_i       = dty;
        dir_tags_i        = tags;
        victim_way_i      = vic;
        #1;
        n_cmp++;
        if ({repl_o, repl_updt_plru_o, repl_set_o, repl_dir_valid_o, alloc_req_ready_o} !==
            {1'b1, 1'b1, set, vld, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_select: got repl %b updt %b set %h dv %b rdy %b want 1 1 %h %b 0",
                     name, repl_o, repl_updt_plru_o, repl_set_o, repl_dir_valid_o,
                     alloc_req_ready_o, set, vld);
        end
        next_cycle();

        // Scramble directory inputs: captured values must not follow them.
        dir_valid_i  = ~vld;
        dir_dirty_i  = ~dty;
        dir_tags_i   = ~tags;
        victim_way_i = {vic[WAYS-2:0], vic[WAYS-1]};
        #1;
        n_cmp++;
        if (repl_o !== 1'b0) begin
            n_fail++; $display("FAIL %s_repl_pulse: got %b want 0", name, repl_o);
        end
        n_cmp++;
        if (wb_valid_o !== exp_dirty) begin
            n_fail++; $display("FAIL %s_wb_valid: got %b want %b", name, wb_valid_o, exp_dirty);
        end

        if (exp_dirty && wb_q.size() > 0) begin
            w = wb_q[0];
            for (int i = 0; i < wb_hold; i++) begin
                wb_ready_i        = 1'b0;
                alloc_rsp_ready_i = 1'b1;
                #1;
                n_cmp++;
                if ({wb_valid_o, alloc_rsp_valid_o, wb_set_o, wb_way_o, wb_tag_o} !==
                    {1'b1, 1'b0, w.set, w.way, w.tag}) begin
                    n_fail++;
                    $display("FAIL %s_wb_hold: got v %b rv %b set %h way %b tag %h want 1 0 %h %b %h",
                             name, wb_valid_o, alloc_rsp_valid_o, wb_set_o, wb_way_o, wb_tag_o,
                             w.set, w.way, w.tag);
                end
                next_cycle();
            end
            alloc_rsp_ready_i = 1'b0;
            wb_ready_i        = 1'b1;
            #1;
            w = wb_q.pop_front();
            n_cmp++;
            if ({wb_valid_o, wb_set_o, wb_way_o, wb_tag_o} !== {1'b1, w.set, w.way, w.tag}) begin
                n_fail++;
                $display("FAIL %s_wb_xfer: got v %b set %h way %b tag %h want 1 %h %b %h",
                         name, wb_valid_o, wb_set_o, wb_way_o, wb_tag_o, w.set, w.way, w.tag);
            end
            next_cycle();
            wb_ready_i = 1'b0;
        end

        // Response must be valid now (cycle 2 clean, or cycle after write-back).
        #1;
        n_cmp++;
        if (alloc_rsp_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL %s_rsp_timing: got %b want 1", name, alloc_rsp_valid_o);
            waited = 0;
            while (alloc_rsp_valid_o !== 1'b1 && waited < 10) begin
                next_cycle();
                waited++;
            end
            n_cmp++;
            if (alloc_rsp_valid_o !== 1'b1) begin
                n_fail++; $display("FAIL %s_rsp_timeout: got %b want 1", name, alloc_rsp_valid_o);
            end
        end

        if (rsp_q.size() > 0) begin
            r = rsp_q[0];
            for (int i = 0; i < rsp_hold; i++) begin
                wb_ready_i = 1'b1;
                #1;
                n_cmp++;
                if ({alloc_rsp_valid_o, wb_valid_o, alloc_rsp_way_o, alloc_rsp_evict_o} !==
                    {1'b1, 1'b0, r.way, r.evict}) begin
                    n_fail++;
                    $display("FAIL %s_rsp_hold: got v %b wv %b way %b ev %b want 1 0 %b %b",
                             name, alloc_rsp_valid_o, wb_valid_o, alloc_rsp_way_o,
                             alloc_rsp_evict_o, r.way, r.evict);
                end
                next_cycle();
            end
            wb_ready_i        = 1'b0;
            alloc_rsp_ready_i = 1'b1;
            #1;
            r = rsp_q.pop_front();
            n_cmp++;
            if ({alloc_rsp_way_o, alloc_rsp_evict_o} !== {r.way, r.evict}) begin
                n_fail++;
                $display("FAIL %s_rsp: got way %b evict %b want %b %b",
                         name, alloc_rsp_way_o, alloc_rsp_evict_o, r.way, r.evict);
            end
        end
        next_cycle();
        alloc_rsp_ready_i = 1'b0;
        victim_way_i      = 4'b0001;
        #1;
        n_cmp++;
        if ({alloc_req_ready_o, alloc_rsp_valid_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s_back_idle: got rdy %b rv %b want 1 0",
                     name, alloc_req_ready_o, alloc_rsp_valid_o);
        end
    endtask

    task automatic test_clean_empty();
        run_alloc("clean_empty", 3'd5, 4'b0000, 4'b0000, 4'b0001, 32'hDEADBEEF, 0, 0);
    endtask

    task automatic test_dirty_wb();
        run_alloc("dirty_wb", 3'd6, 4'b1111, 4'b0100, 4'b0100, 32'h113A2233, 3, 2);
    endtask

    task automatic test_dirty_invalid();
        run_alloc("dirty_inval", 3'd2, 4'b1011, 4'b0100, 4'b0100, 32'h44556677, 0, 1);
    endtask

    task automatic test_clean_evict();
        run_alloc("clean_evict", 3'd7, 4'b1111, 4'b0111, 4'b1000, 32'hA1B2C3D4, 0, 0);
    endtask

    task automatic test_dirty_way0();
        run_alloc("dirty_way0", 3'd1, 4'b0001, 4'b1111, 4'b0001, 32'h000000C5, 1, 0);
    endtask

    // Continuous requests with the response side always ready.
    task automatic test_back_to_back();
        rsp_t r;
        logic exp_acc;
        logic exp_rv;
        alloc_rsp_ready_i = 1'b1;
        dir_valid_i       = '0;
        dir_dirty_i       = '0;
        for (int c = 0; c < 9; c++) begin
            alloc_req_valid_i = 1'b1;
            alloc_req_set_i   = SW'(c);
            victim_way_i      = WAYS'(1 << (c % WAYS));
            exp_acc           = (c % 3 == 0);
            exp_rv            = (c % 3 == 2);
            #1;
            n_cmp++;
            if ({alloc_req_ready_o, dir_rd_o, alloc_rsp_valid_o} !== {exp_acc, exp_acc, exp_rv}) begin
                n_fail++;
                $display("FAIL b2b_c%0d: got rdy %b rd %b rv %b want %b %b %b", c,
                         alloc_req_ready_o, dir_rd_o, alloc_rsp_valid_o, exp_acc, exp_acc, exp_rv);
            end
            if (exp_acc) rsp_q.push_back('{way: WAYS'(1 << ((c + 1) % WAYS)), evict: 1'b0});
            if (alloc_rsp_valid_o === 1'b1 && rsp_q.size() > 0) begin
                r = rsp_q.pop_front();
                n_cmp++;
                if ({alloc_rsp_way_o, alloc_rsp_evict_o} !== {r.way, r.evict}) begin
                    n_fail++;
                    $display("FAIL b2b_rsp_c%0d: got way %b ev %b want %b %b", c,
                             alloc_rsp_way_o, alloc_rsp_evict_o, r.way, r.evict);
                end
            end
            next_cycle();
        end
        alloc_req_valid_i = 1'b0;
        alloc_rsp_ready_i = 1'b0;
        victim_way_i      = 4'b0001;
        n_cmp++;
        if (rsp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_drain: got %0d pending want 0", rsp_q.size());
        end
        rsp_q.delete();
    endtask

    // Reset hits while a write-back is pending; the allocation is abandoned.
    task automatic test_reset_mid_wb();
        alloc_req_valid_i = 1'b1;
        alloc_req_set_i   = 3'd4;
        next_cycle();
        alloc_req_valid_i = 1'b0;
        dir_valid_i       = 4'b1111;
        dir_dirty_i       = 4'b1111;
        dir_tags_i        = 32'h0F1E2D3C;
        victim_way_i      = 4'b0010;
        next_cycle();
        #1;
        n_cmp++;
        if (wb_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL rstwb_enter: got wb_valid %b want 1", wb_valid_o);
        end
        #1;
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({wb_valid_o, alloc_rsp_valid_o, alloc_req_ready_o, repl_o} !== 4'b0010) begin
            n_fail++;
            $display("FAIL rstwb_async: got wv %b rv %b rdy %b repl %b want 0 0 1 0",
                     wb_valid_o, alloc_rsp_valid_o, alloc_req_ready_o, repl_o);
        end
        @(negedge clk_i);
        rst_i             = 1'b0;
        wb_ready_i        = 1'b1;
        alloc_rsp_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++;
            if ({alloc_req_ready_o, wb_valid_o, alloc_rsp_valid_o} !== 3'b100) begin
                n_fail++;
                $display("FAIL rstwb_idle_c%0d: got rdy %b wv %b rv %b want 1 0 0", c,
                         alloc_req_ready_o, wb_valid_o, alloc_rsp_valid_o);
            end
            next_cycle();
        end
        wb_ready_i        = 1'b0;
        alloc_rsp_ready_i = 1'b0;
        victim_way_i      = 4'b0001;
        rsp_q.delete();
        wb_q.delete();
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_clean_empty();
        test_dirty_wb();
        test_dirty_invalid();
        test_clean_evict();
        test_dirty_way0();
        test_back_to_back();
        test_reset_mid_wb();
        // Normal operation must resume after the abandoned allocation.
        test_dirty_wb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/hpdcache_victim_alloc.md
# hpdcache_victim_alloc

Refill-side victim allocator sitting directly in front of `hpdcache_plru`. On a miss-refill allocation request it:
- reads the set's directory entry;
- drives the PLRU replacement interface and captures the selected victim way;
- issues a write-back request when the victim is dirty;
- returns the allocated way to the miss handler.

It is the sole producer of `repl_i`, `repl_set_i`, `repl_dir_valid_i` and `repl_updt_plru_i` on the PLRU.

## Interface
Parameters:
- `SETS`, 0, number of sets (power of two, ≥2)
- `WAYS`, 0, number of ways (≥2)
- `TAG_WIDTH`, 0, tag bits per directory entry

Ports:
- `clk_i`  in  1  clock. The block uses one clock.
- `rst_i`  in  1  reset, asynchronous, active-high
- `alloc_req_valid_i`  in  1  allocation request valid
- `alloc_req_ready_o`  out  1  accept; high only in IDLE
- `alloc_req_set_i`  in  log2(SETS)  target set
- `dir_rd_o`  out  1  directory read strobe
- `dir_rd_set_o`  out  log2(SETS)  directory read set
- `dir_valid_i`  in  WAYS  per-way valid bits, returned one cycle after `dir_rd_o`
- `dir_dirty_i`  in  WAYS  per-way dirty bits, same timing as `dir_valid_i`
- `dir_tags_i`  in  WAYS*TAG_WIDTH  tags; way w occupies `[w*TAG_WIDTH +: TAG_WIDTH]`
- `repl_o`, `repl_set_o`, `repl_dir_valid_o`, `repl_updt_plru_o`  out  1 / log2(SETS) / WAYS / 1  PLRU replacement interface
- `victim_way_i`  in  WAYS  one-hot victim, combinational from the PLRU in the same cycle
- `wb_valid_o`  out  1  write-back request valid
- `wb_ready_i`  in  1  write-back request accept
- `wb_set_o`, `wb_way_o`, `wb_tag_o`  out  log2(SETS) / WAYS / TAG_WIDTH  evicted line identity
- `alloc_rsp_valid_o`  out  1  allocation result valid
- `alloc_rsp_ready_i`  in  1  allocation result accept
- `alloc_rsp_way_o`  out  WAYS  allocated way, one-hot
- `alloc_rsp_evict_o`  out  1  victim held a valid line

## Operation
The FSM has four states: IDLE, SELECT, WB, RSP.

IDLE
- `alloc_req_ready_o`=1.
- On `alloc_req_valid_i`:
  - latch the set into `set_q`;
  - assert `dir_rd_o` with `dir_rd_set_o`=`alloc_req_set_i` in the same cycle;
  - go to SELECT.

SELECT
- Directory data is valid this cycle.
- Drive `repl_o`=1, `repl_set_o`=`set_q`, `repl_dir_valid_o`=`dir_valid_i`, `repl_updt_plru_o`=1 for exactly one cycle.
- Latch into registers:
  - `way_q`=`victim_way_i`;
  - `evict_q`=|(`victim_way_i` & `dir_valid_i`);
  - `dirty_q`=|(`victim_way_i` & `dir_valid_i` & `dir_dirty_i`);
  - `tag_q`=one-hot mux of `dir_tags_i` by `victim_way_i`.
- Next state is WB if the dirty term is set, else RSP.

WB
- `wb_valid_o`=1 with `wb_set_o`=`set_q`, `wb_way_o`=`way_q`, `wb_tag_o`=`tag_q`.
- Payload is stable while waiting.
- On `wb_ready_i`, go to RSP.

RSP
- `alloc_rsp_valid_o`=1 with `alloc_rsp_way_o`=`way_q`, `alloc_rsp_evict_o`=`evict_q`.
- On `alloc_rsp_ready_i`, go to IDLE.

General rules
- Valid/ready handshakes: a transfer occurs when both are high on a rising edge. Once asserted, a valid stays asserted with a stable payload until the transfer.
- `repl_o` is never asserted outside SELECT. The PLRU's `updt_i` path is independent and may coincide; the PLRU gives `repl_i` priority.
- Dirty on an invalid way is ignored: no write-back, `alloc_rsp_evict_o`=0.
- At most one allocation is in flight. Requests presented outside IDLE are not accepted.

## Timing
- Reset values:
  - state=IDLE, so `alloc_req_ready_o`=1;
  - `dir_rd_o`, `repl_o`, `repl_updt_plru_o`, `wb_valid_o`, `alloc_rsp_valid_o` = 0;
  - all payload registers = 0.
- Clean victim: request accepted in cycle 0, SELECT in cycle 1, `alloc_rsp_valid_o` in cycle 2.
- Dirty victim: `wb_valid_o` from cycle 2; `alloc_rsp_valid_o` in the cycle after the `wb_ready_i` handshake.
- Minimum spacing between accepted requests is 3 cycles (IDLE→SELECT→RSP→IDLE).
- Reset asserted mid-operation: immediate return to IDLE. All valids drop asynchronously, and the in-flight allocation is dropped with no response.
- `wb_ready_i` and `alloc_rsp_ready_i` high outside their states are ignored.
- Assertions:
  - `victim_way_i` is one-hot whenever `repl_o`=1;
  - `wb_valid_o` and `alloc_rsp_valid_o` are never high together.

## Structure
- Derived typedefs `set_t`, `way_vector_t`, `tag_t` are built from the parameters.
- The FSM state enum is local to the module. Nothing goes into the shared package beyond existing types.
- One natural sub-module: `hpdcache_mux_1hot` (parameters N, WIDTH) for tag selection, reusable elsewhere.

## Test plan
- Reset, then `alloc_req_valid_i`=1, set 5, `dir_valid_i`=4'b0000, `victim_way_i`=4'b0001 → `repl_o` pulses in cycle 1 with `repl_dir_valid_o`=0; cycle 2 `alloc_rsp_valid_o`=1, way 4'b0001, evict=0; no `wb_valid_o`.
- Full set, `dir_valid_i`=4'b1111, `dir_dirty_i`=4'b0100, victim 4'b0100, tag[2]=0x3A → `wb_valid_o` cycle 2 with tag 0x3A, way 4'b0100, set `set_q`. Hold `wb_ready_i`=0 for 3 cycles → payload stable. Response comes one cycle after the handshake, with evict=1.
- Dirty bit on an invalid victim (valid 4'b1011, dirty 4'b0100, victim 4'b0100) → no write-back, evict=0.
- Back-to-back requests with `alloc_rsp_ready_i` tied 1 → accepts at cycles 0, 3, 6; `alloc_req_ready_o` low in cycles 1–2, 4–5.
- Assert `rst_i` while in WB → `wb_valid_o` drops without a clock edge; state IDLE and `alloc_req_ready_o`=1 after release; no response is issued.
